// File: rtl/block_word_streamer_pkg.sv
// Shared types for the block word streamer: legacy cache word/block types and the streamer FSM states.
package block_word_streamer_pkg;

  localparam int unsigned LC3B_WORD_W  = 16;
  localparam int unsigned LC3B_BLOCK_W = 128;

  typedef logic [LC3B_WORD_W-1:0]  lc3b_word;
  typedef logic [LC3B_BLOCK_W-1:0] lc3b_block;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } streamer_state_t;

endpackage

// File: rtl/block_word_streamer_if.sv
// Load/stream handshake bundle between the cache datapath, the streamer and the word consumer.
interface block_word_streamer_if #(
  parameter int unsigned DATA_WORDS = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LOG_WORD   = 3
);

  logic                             load_valid;
  logic                             load_ready;
  logic [DATA_WORDS*WORD_WIDTH-1:0] load_block;
  logic [LOG_WORD-1:0]              load_offset;
  logic                             flush;
  logic                             word_valid;
  logic                             word_ready;
  logic [WORD_WIDTH-1:0]            word_data;
  logic [LOG_WORD-1:0]              word_index;
  logic                             word_last;
  logic                             busy;

  // Producer/consumer side that drives blocks in and takes words out
  modport master (
    output load_valid, load_block, load_offset, flush, word_ready,
    input  load_ready, word_valid, word_data, word_index, word_last, busy
  );

  // Streamer side
  modport slave (
    input  load_valid, load_block, load_offset, flush, word_ready,
    output load_ready, word_valid, word_data, word_index, word_last, busy
  );

endinterface

// File: rtl/block_word_streamer_select.sv
// Combinational word mux: picks word[index] out of a packed block; shared with the cache read path.
module block_word_select #(
  parameter int unsigned DATA_WORDS = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LOG_WORD   = 3
) (
  input  logic [DATA_WORDS*WORD_WIDTH-1:0] block,
  input  logic [LOG_WORD-1:0]              index,
  output logic [WORD_WIDTH-1:0]            word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < DATA_WORDS; i++) begin
      if (index == LOG_WORD'(i)) begin
        word = block[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

endmodule

// File: rtl/block_word_streamer.sv
// Captures one cache block and streams its words one per handshake, critical-word-first or linear.
module block_word_streamer
  import block_word_streamer_pkg::*;
#(
  parameter int unsigned DATA_WORDS = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LOG_WORD   = 3,
  parameter bit          WRAP_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  block_word_streamer_if.slave bus
);

  localparam int unsigned       BLOCK_W    = DATA_WORDS * WORD_WIDTH;
  localparam logic [LOG_WORD-1:0] LAST_COUNT = LOG_WORD'(DATA_WORDS - 1);

  streamer_state_t     state_q, state_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [LOG_WORD-1:0] index_q, index_d;
  logic [LOG_WORD-1:0] count_q, count_d;

  logic streaming;
  logic handshake;
  logic at_last;
  logic load_ready_c;
  logic load_fire;

  assign streaming    = (state_q == STREAM);
  assign handshake    = streaming && bus.word_ready;
  assign at_last      = (count_q == LAST_COUNT);
  // A new block may be taken in IDLE, or in the final handshake so streams run back to back
  assign load_ready_c = !bus.flush && (!streaming || (handshake && at_last));
  assign load_fire    = bus.load_valid && load_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      block_q <= '0;
      index_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    block_d = block_q;
    index_d = index_q;
    count_d = count_q;
    if (bus.flush) begin
      // Abort drops the captured block; an idle flush leaves everything untouched
      if (streaming) begin
        state_d = IDLE;
        block_d = '0;
        index_d = '0;
        count_d = '0;
      end
    end else if (load_fire) begin
      state_d = STREAM;
      block_d = bus.load_block;
      index_d = WRAP_EN ? bus.load_offset : '0;
      count_d = '0;
    end else if (handshake) begin
      index_d = index_q + LOG_WORD'(1);
      count_d = count_q + LOG_WORD'(1);
      if (at_last) begin
        state_d = IDLE;
      end
    end
  end

  block_word_select #(
    .DATA_WORDS (DATA_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .LOG_WORD   (LOG_WORD)
  ) u_select (
    .block (block_q),
    .index (index_q),
    .word  (bus.word_data)
  );

  assign bus.load_ready = load_ready_c;
  assign bus.word_valid = streaming;
  assign bus.busy       = streaming;
  assign bus.word_index = index_q;
  assign bus.word_last  = streaming && at_last;

endmodule

// File: tb/tb_block_word_streamer.sv
// Drives a wrapping and a linear streamer with identical stimulus and checks both against a word-queue model.
module tb_block_word_streamer;

  localparam int unsigned N  = 8;
  localparam int unsigned WW = 16;
  localparam int unsigned LW = 3;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [LW-1:0] idx;
  } ent_t;

  logic clk;
  logic reset;

  block_word_streamer_if #(.DATA_WORDS(N), .WORD_WIDTH(WW), .LOG_WORD(LW)) bus_w ();
  block_word_streamer_if #(.DATA_WORDS(N), .WORD_WIDTH(WW), .LOG_WORD(LW)) bus_l ();

  block_word_streamer #(.DATA_WORDS(N), .WORD_WIDTH(WW), .LOG_WORD(LW), .WRAP_EN(1'b1)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  block_word_streamer #(.DATA_WORDS(N), .WORD_WIDTH(WW), .LOG_WORD(LW), .WRAP_EN(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t q_w[$];
  ent_t q_l[$];
  logic after_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word sequence of one stream, computed from the block and ordering rule
  function automatic void push_stream(input logic wrap, input logic [N*WW-1:0] blk,
                                      input logic [LW-1:0] off, inout ent_t q[$]);
    for (int k = 0; k < int'(N); k++) begin
      int   i;
      ent_t e;
      i      = wrap ? (int'(off) + k) % int'(N) : k;
      e.idx  = LW'(i);
      e.data = blk[i*WW +: WW];
      q.push_back(e);
    end
  endfunction

  task automatic check_dut(input string nm, input int qsz, input ent_t front, input logic exp_lr,
                           input logic v, input logic [WW-1:0] d, input logic [LW-1:0] ix,
                           input logic last, input logic bsy, input logic lr);
    check({nm, ".word_valid"}, 32'(v), 32'(qsz > 0));
    check({nm, ".busy"}, 32'(bsy), 32'(qsz > 0));
    check({nm, ".load_ready"}, 32'(lr), 32'(exp_lr));
    check({nm, ".word_last"}, 32'(last), 32'(qsz == 1));
    if (qsz > 0) begin
      check({nm, ".word_data"}, 32'(d), 32'(front.data));
      check({nm, ".word_index"}, 32'(ix), 32'(front.idx));
    end
    if (after_rst) begin
      check({nm, ".rst_data"}, 32'(d), 32'h0);
      check({nm, ".rst_index"}, 32'(ix), 32'h0);
    end
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance the model at the next edge
  task automatic step(input logic rst, input logic lv, input logic [N*WW-1:0] blk,
                      input logic [LW-1:0] off, input logic fl, input logic rdy);
    logic exp_lr;
    ent_t fw, fl_e;
    reset             = rst;
    bus_w.load_valid  = lv;   bus_l.load_valid  = lv;
    bus_w.load_block  = blk;  bus_l.load_block  = blk;
    bus_w.load_offset = off;  bus_l.load_offset = off;
    bus_w.flush       = fl;   bus_l.flush       = fl;
    bus_w.word_ready  = rdy;  bus_l.word_ready  = rdy;
    @(negedge clk);
    exp_lr = !fl && (q_w.size() == 0 || (q_w.size() == 1 && rdy));
    fw   = (q_w.size() > 0) ? q_w[0] : '0;
    fl_e = (q_l.size() > 0) ? q_l[0] : '0;
    check_dut("wrap", q_w.size(), fw, exp_lr, bus_w.word_valid, bus_w.word_data,
              bus_w.word_index, bus_w.word_last, bus_w.busy, bus_w.load_ready);
    check_dut("lin", q_l.size(), fl_e, exp_lr, bus_l.word_valid, bus_l.word_data,
              bus_l.word_index, bus_l.word_last, bus_l.busy, bus_l.load_ready);
    @(posedge clk);
    after_rst = rst;
    if (rst || fl) begin
      q_w.delete();
      q_l.delete();
    end else begin
      if (q_w.size() > 0 && rdy) void'(q_w.pop_front());
      if (q_l.size() > 0 && rdy) void'(q_l.pop_front());
      if (lv && exp_lr) begin
        push_stream(1'b1, blk, off, q_w);
        push_stream(1'b0, blk, off, q_l);
      end
    end
    #1;
  endtask

  logic [N*WW-1:0] blk_a, blk_b, rnd_blk;

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      blk_a[i*WW +: WW] = WW'(16'h1000 + i);
      blk_b[i*WW +: WW] = WW'(16'h2000 + i);
    end
    reset = 1'b1;
    bus_w.load_valid = 1'b0; bus_l.load_valid = 1'b0;
    bus_w.load_block = '0;   bus_l.load_block = '0;
    bus_w.load_offset = '0;  bus_l.load_offset = '0;
    bus_w.flush = 1'b0;      bus_l.flush = 1'b0;
    bus_w.word_ready = 1'b0; bus_l.word_ready = 1'b0;
    @(posedge clk); #1;

    // Reset, then a full stream at offset 5 with no backpressure
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1);
    step(0, 1, blk_a, 3'd5, 0, 1);
    for (int k = 0; k < int'(N); k++) step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);

    // Backpressure on the third word
    step(0, 1, blk_a, 3'd5, 0, 1);
    step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 0, 0);
    for (int k = 0; k < int'(N) - 1; k++) step(0, 0, '0, 0, 0, 1);

    // Back-to-back blocks, second loaded during the last handshake
    step(0, 1, blk_a, 3'd5, 0, 1);
    for (int k = 0; k < int'(N) - 1; k++) step(0, 0, '0, 0, 0, 1);
    step(0, 1, blk_b, 3'd0, 0, 1);
    for (int k = 0; k < int'(N); k++) step(0, 0, '0, 0, 0, 1);

    // Flush on the fourth word with a competing load, then a fresh stream
    step(0, 1, blk_a, 3'd5, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 0, 1);
    step(0, 1, blk_b, 3'd1, 1, 1);
    step(0, 0, '0, 0, 0, 1);
    step(0, 1, blk_b, 3'd2, 0, 1);
    for (int k = 0; k < int'(N); k++) step(0, 0, '0, 0, 0, 1);

    // Reset mid-stream
    step(0, 1, blk_a, 3'd3, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 0, 1);
    step(1, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) rnd_blk[i*WW +: WW] = WW'($urandom);
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1),
           rnd_blk,
           LW'($urandom_range(0, N - 1)),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
